// File: rtl/eurorack_pkg.sv
// Shared definitions for the eurorack capture path: write-FSM states and
// overflow counter limits.
package eurorack_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_e;

  localparam logic [15:0] OVERFLOW_MAX = 16'hFFFF;

  // Saturating increment used by the dropped-frame counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == OVERFLOW_MAX) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sample_capture_ram.sv
// Simple dual-port word store: one synchronous write port and one
// asynchronous read port so the FIFO head can fall through.
module sample_capture_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sample_capture_fifo.sv
// Captures 4-channel calibrated sample frames on each clk_fs rising edge and
// streams them out word by word through a first-word-fall-through FIFO.
module sample_capture_fifo
  import eurorack_pkg::*;
#(
  parameter int W            = 16,
  parameter int DEPTH_FRAMES = 64
) (
  input  logic                                  clk_256fs,
  input  logic                                  rst,
  input  logic                                  clk_fs,
  input  logic signed [W-1:0]                   cal_in0,
  input  logic signed [W-1:0]                   cal_in1,
  input  logic signed [W-1:0]                   cal_in2,
  input  logic signed [W-1:0]                   cal_in3,
  input  logic                                  enable,
  input  logic                                  flush,
  output logic [W-1:0]                          m_data,
  output logic [1:0]                            m_chan,
  output logic                                  m_last,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [$clog2(4*DEPTH_FRAMES):0]       level,
  output logic [15:0]                           overflow_count
);

  localparam int NWORDS = 4 * DEPTH_FRAMES;
  localparam int AW     = $clog2(NWORDS);
  localparam int LW     = AW + 1;

  logic              clk_fs_d_r;
  logic              strobe_s;
  wr_state_e         state_r;
  logic [1:0]        idx_r;
  logic [W-1:0]      frame_r [4];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic [LW-1:0]     level_next_s;
  logic [LW-1:0]     free_s;
  logic              valid_r;
  logic [15:0]       ovf_cnt_r;
  logic              room_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic              start_s;
  logic              drop_s;
  logic [W-1:0]      rdata_s;

  assign strobe_s = clk_fs & ~clk_fs_d_r;

  // Control decode: frame start, frame drop and the handshake-driven level update.
  always_comb begin
    free_s       = LW'(NWORDS) - level_r;
    room_s       = (free_s >= LW'(3'd4));
    wr_en_s      = (state_r == WRITE) && !flush;
    rd_en_s      = valid_r && m_ready && !flush;
    start_s      = 1'b0;
    drop_s       = 1'b0;
    level_next_s = level_r;
    if (strobe_s && enable && !flush) begin
      if (state_r == IDLE) begin
        start_s = room_s;
        drop_s  = !room_s;
      end else begin
        drop_s  = 1'b1;
      end
    end else begin
      start_s = 1'b0;
      drop_s  = 1'b0;
    end
    if (flush) begin
      level_next_s = '0;
    end else begin
      case ({wr_en_s, rd_en_s})
        2'b10:   level_next_s = level_r + LW'(1'b1);
        2'b01:   level_next_s = level_r - LW'(1'b1);
        default: level_next_s = level_r;
      endcase
    end
  end

  // Edge-detect register for the sample-rate clock.
  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      clk_fs_d_r <= 1'b0;
    end else begin
      clk_fs_d_r <= clk_fs;
    end
  end

  // Frame holding register, loaded when a capture starts.
  always_ff @(posedge clk_256fs) begin
    if (start_s) begin
      frame_r[0] <= cal_in0;
      frame_r[1] <= cal_in1;
      frame_r[2] <= cal_in2;
      frame_r[3] <= cal_in3;
    end
  end

  // Write FSM, pointers, level and the registered valid flag.
  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= 2'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      valid_r  <= 1'b0;
    end else if (flush) begin
      state_r  <= IDLE;
      idx_r    <= 2'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      level_r <= level_next_s;
      valid_r <= (level_next_s != '0);
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r <= WRITE;
            idx_r   <= 2'd0;
          end
        end
        WRITE: begin
          wr_ptr_r <= wr_ptr_r + AW'(1'b1);
          idx_r    <= idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= 2'd0;
        end
      endcase
    end
  end

  // Dropped-frame counter; flush deliberately leaves it alone.
  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      ovf_cnt_r <= 16'd0;
    end else if (drop_s) begin
      ovf_cnt_r <= sat_inc16(ovf_cnt_r);
    end
  end

  sample_capture_ram #(
    .W     (W),
    .DEPTH (NWORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk_256fs),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata (frame_r[idx_r]),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  assign m_data         = rdata_s;
  assign m_chan         = rd_ptr_r[1:0];
  assign m_last         = (rd_ptr_r[1:0] == 2'd3);
  assign m_valid        = valid_r;
  assign level          = level_r;
  assign overflow_count = ovf_cnt_r;

endmodule
